// File: rtl/game_ctrl.sv
// Game-flow controller: board selection, move counting with a move limit, pause and best score.
// Optional per-game timer with timeout is built when the GAME_TIMER_EN macro is defined.
module game_ctrl #(
    parameter int STEP_W     = 6,
    parameter int MAX_STEPS  = 63,
    parameter int TIME_LIMIT = 99
) (
    input  logic              clk_d,
    input  logic              rst,
    input  logic              start_sw,
    input  logic              win_flag,
    input  logic              active,
    input  logic              reset_flag,
    input  logic              pause_sw,
`ifdef GAME_TIMER_EN
    input  logic              tick_1hz,
`endif
    output logic [2:0]        game_status,
    output logic [STEP_W-1:0] step_number,
    output logic [STEP_W-1:0] best_steps,
    output logic              best_valid,
    output logic              new_record
`ifdef GAME_TIMER_EN
    ,
    output logic [6:0]        elapsed_sec
`endif
);

    typedef enum logic [2:0] {
        CHOSE_BOARD  = 3'd0,
        GAME_INITIAL = 3'd1,
        GAMING       = 3'd2,
        PAUSED       = 3'd3,
        WINNED       = 3'd4,
        LOST         = 3'd5
    } state_t;

    localparam logic [STEP_W-1:0] MAX_STEP_V = STEP_W'(MAX_STEPS);

    // Elaboration-time guard against limits that cannot be represented.
    generate
        if (MAX_STEPS < 1 || MAX_STEPS > (2**STEP_W) - 1 || TIME_LIMIT < 1 || TIME_LIMIT > 127) begin : g_bad_params
            $error("game_ctrl: MAX_STEPS or TIME_LIMIT out of range");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [STEP_W-1:0] step_reg, step_next;
    logic [STEP_W-1:0] best_reg, best_next;
    logic              best_valid_reg, best_valid_next;
    logic              new_record_reg, new_record_next;
`ifdef GAME_TIMER_EN
    localparam logic [6:0] TIME_LIMIT_V = 7'(TIME_LIMIT);
    logic [6:0]        elapsed_reg, elapsed_next;
`endif

    always_comb begin
        state_next      = state_reg;
        step_next       = step_reg;
        best_next       = best_reg;
        best_valid_next = best_valid_reg;
        new_record_next = 1'b0;
`ifdef GAME_TIMER_EN
        elapsed_next    = elapsed_reg;
`endif
        if (!start_sw) begin
            state_next = CHOSE_BOARD;
            step_next  = '0;
`ifdef GAME_TIMER_EN
            elapsed_next = '0;
`endif
        end else begin
            case (state_reg)
                CHOSE_BOARD: begin
                    step_next  = '0;
                    state_next = GAME_INITIAL;
`ifdef GAME_TIMER_EN
                    elapsed_next = '0;
`endif
                end
                GAME_INITIAL, GAMING: begin
                    if (win_flag) begin
                        state_next = WINNED;
                        // Ties keep the earlier record.
                        if (!best_valid_reg || step_reg < best_reg) begin
                            best_next       = step_reg;
                            best_valid_next = 1'b1;
                            new_record_next = 1'b1;
                        end
`ifdef GAME_TIMER_EN
                    end else if (tick_1hz && elapsed_reg == TIME_LIMIT_V) begin
                        state_next = LOST;
`endif
                    end else if (active && step_reg == MAX_STEP_V) begin
                        state_next = LOST;
                    end else begin
`ifdef GAME_TIMER_EN
                        if (tick_1hz) begin
                            elapsed_next = elapsed_reg + 7'd1;
                        end
`endif
                        if (active) begin
                            step_next  = step_reg + STEP_W'(1);
                            state_next = GAMING;
                        end else if (reset_flag) begin
                            step_next  = '0;
                            state_next = GAME_INITIAL;
`ifdef GAME_TIMER_EN
                            elapsed_next = '0;
`endif
                        end else if (pause_sw) begin
                            state_next = PAUSED;
                        end
                    end
                end
                PAUSED: begin
                    if (!pause_sw) begin
                        state_next = (step_reg == '0) ? GAME_INITIAL : GAMING;
                    end
                end
                WINNED, LOST: begin
                    state_next = state_reg;
                end
                default: begin
                    state_next = CHOSE_BOARD;
                    step_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_d) begin
        if (rst) begin
            state_reg      <= CHOSE_BOARD;
            step_reg       <= '0;
            best_reg       <= '0;
            best_valid_reg <= 1'b0;
            new_record_reg <= 1'b0;
`ifdef GAME_TIMER_EN
            elapsed_reg    <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            step_reg       <= step_next;
            best_reg       <= best_next;
            best_valid_reg <= best_valid_next;
            new_record_reg <= new_record_next;
`ifdef GAME_TIMER_EN
            elapsed_reg    <= elapsed_next;
`endif
        end
    end

    assign game_status = state_reg;
    assign step_number = step_reg;
    assign best_steps  = best_reg;
    assign best_valid  = best_valid_reg;
    assign new_record  = new_record_reg;
`ifdef GAME_TIMER_EN
    assign elapsed_sec = elapsed_reg;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: a vector table on a default-size instance plus
// hand sequences on a small instance for move limit and (with GAME_TIMER_EN) timeout.
module tb_game_ctrl;

    logic       clk_d = 1'b0;
    logic       rst = 1'b1;
    logic       start_sw = 1'b0;
    logic       win_flag = 1'b0;
    logic       active = 1'b0;
    logic       reset_flag = 1'b0;
    logic       pause_sw = 1'b0;
`ifdef GAME_TIMER_EN
    logic       tick_1hz = 1'b0;
    logic [6:0] elapsed_a, elapsed_b;
`endif

    logic [2:0] status_a, status_b;
    logic [5:0] step_a, best_a;
    logic [3:0] step_b, best_b;
    logic       bv_a, bv_b, nr_a, nr_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_d = ~clk_d;

    game_ctrl #(.STEP_W(6), .MAX_STEPS(63), .TIME_LIMIT(99)) dut_a (
        .clk_d(clk_d), .rst(rst), .start_sw(start_sw), .win_flag(win_flag),
        .active(active), .reset_flag(reset_flag), .pause_sw(pause_sw),
`ifdef GAME_TIMER_EN
        .tick_1hz(tick_1hz),
`endif
        .game_status(status_a), .step_number(step_a), .best_steps(best_a),
        .best_valid(bv_a), .new_record(nr_a)
`ifdef GAME_TIMER_EN
        , .elapsed_sec(elapsed_a)
`endif
    );

    game_ctrl #(.STEP_W(4), .MAX_STEPS(5), .TIME_LIMIT(3)) dut_b (
        .clk_d(clk_d), .rst(rst), .start_sw(start_sw), .win_flag(win_flag),
        .active(active), .reset_flag(reset_flag), .pause_sw(pause_sw),
`ifdef GAME_TIMER_EN
        .tick_1hz(tick_1hz),
`endif
        .game_status(status_b), .step_number(step_b), .best_steps(best_b),
        .best_valid(bv_b), .new_record(nr_b)
`ifdef GAME_TIMER_EN
        , .elapsed_sec(elapsed_b)
`endif
    );

    typedef struct {
        int st, wn, ac, rf, ps;
        int e_status, e_step, e_best, e_bv, e_nr;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic cyc(input int st, input int wn, input int ac, input int rf, input int ps);
        @(negedge clk_d);
        start_sw   = (st != 0);
        win_flag   = (wn != 0);
        active     = (ac != 0);
        reset_flag = (rf != 0);
        pause_sw   = (ps != 0);
        @(posedge clk_d);
        #1;
    endtask

    task automatic check_a(input string tag, input int s, input int stp, input int b, input int bv, input int nr);
        check({tag, " status"}, 32'(status_a), s);
        check({tag, " step"}, 32'(step_a), stp);
        check({tag, " best"}, 32'(best_a), b);
        check({tag, " best_valid"}, 32'(bv_a), bv);
        check({tag, " new_record"}, 32'(nr_a), nr);
    endtask

    task automatic play_a(input int n, input int exp_best, input int exp_nr);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check_a($sformatf("best win%0d", n), 4, n, exp_best, 1, exp_nr);
        cyc(0, 0, 0, 0, 0);
        check($sformatf("best win%0d exit status", n), 32'(status_a), 0);
    endtask

    initial begin
        // st wn ac rf ps | status step best bv nr
        vecs[0]  = '{1,0,0,0,0, 1,0,0,0,0};
        vecs[1]  = '{1,0,1,0,0, 2,1,0,0,0};
        vecs[2]  = '{1,0,1,0,0, 2,2,0,0,0};
        vecs[3]  = '{1,0,1,0,0, 2,3,0,0,0};
        vecs[4]  = '{1,1,0,0,0, 4,3,3,1,1};
        vecs[5]  = '{1,1,0,0,0, 4,3,3,1,0};
        vecs[6]  = '{1,0,1,0,0, 4,3,3,1,0};
        vecs[7]  = '{0,0,0,0,0, 0,0,3,1,0};
        vecs[8]  = '{1,0,0,0,0, 1,0,3,1,0};
        vecs[9]  = '{1,0,1,0,0, 2,1,3,1,0};
        vecs[10] = '{1,0,1,0,0, 2,2,3,1,0};
        vecs[11] = '{1,0,1,1,0, 2,3,3,1,0};
        vecs[12] = '{1,0,1,0,0, 2,4,3,1,0};
        vecs[13] = '{1,1,1,0,0, 4,4,3,1,0};
        vecs[14] = '{0,0,0,0,0, 0,0,3,1,0};
        vecs[15] = '{1,0,0,0,0, 1,0,3,1,0};
        vecs[16] = '{1,0,1,0,0, 2,1,3,1,0};
        vecs[17] = '{1,0,1,0,0, 2,2,3,1,0};
        vecs[18] = '{1,0,0,0,1, 3,2,3,1,0};
        vecs[19] = '{1,0,1,0,1, 3,2,3,1,0};
        vecs[20] = '{1,0,1,0,1, 3,2,3,1,0};
        vecs[21] = '{1,1,0,0,1, 3,2,3,1,0};
        vecs[22] = '{1,0,0,0,0, 2,2,3,1,0};
        vecs[23] = '{1,0,0,1,0, 1,0,3,1,0};
        vecs[24] = '{1,0,0,0,1, 3,0,3,1,0};
        vecs[25] = '{1,0,0,0,0, 1,0,3,1,0};
        vecs[26] = '{0,0,0,0,0, 0,0,3,1,0};

        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check_a("reset", 0, 0, 0, 0, 0);
        @(negedge clk_d);
        rst = 1'b0;

        for (int i = 0; i < 27; i++) begin
            cyc(vecs[i].st, vecs[i].wn, vecs[i].ac, vecs[i].rf, vecs[i].ps);
            check_a($sformatf("vec%0d", i), vecs[i].e_status, vecs[i].e_step,
                    vecs[i].e_best, vecs[i].e_bv, vecs[i].e_nr);
        end

        // rst mid-game clears everything, including the best score.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        @(negedge clk_d);
        rst = 1'b1;
        cyc(1, 0, 0, 0, 0);
        check_a("midgame rst", 0, 0, 0, 0, 0);
        @(negedge clk_d);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);

        play_a(7, 7, 1);
        play_a(9, 7, 0);
        play_a(4, 4, 1);

        // Move limit on the small instance.
        @(negedge clk_d);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        @(negedge clk_d);
        rst = 1'b0;
        cyc(1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 0, 1, 0, 0);
            check($sformatf("limit step%0d", i), 32'(step_b), i);
            check($sformatf("limit status%0d", i), 32'(status_b), 2);
        end
        cyc(1, 0, 1, 0, 0);
        check("limit 6th status", 32'(status_b), 5);
        check("limit 6th step", 32'(step_b), 5);
        cyc(1, 0, 1, 0, 0);
        check("limit 7th step", 32'(step_b), 5);
        cyc(1, 1, 0, 0, 0);
        check("lost win status", 32'(status_b), 5);
        check("lost best_valid", 32'(bv_b), 0);
        cyc(0, 0, 0, 0, 0);
        check("lost exit status", 32'(status_b), 0);
        check("lost exit step", 32'(step_b), 0);

`ifdef GAME_TIMER_EN
        cyc(1, 0, 0, 0, 0);
        check("timer start elapsed", 32'(elapsed_b), 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_d);
            tick_1hz = 1'b1;
            @(posedge clk_d);
            #1;
            check($sformatf("timer tick%0d elapsed", i), 32'(elapsed_b), (i < 4) ? i : 3);
            check($sformatf("timer tick%0d status", i), 32'(status_b), (i < 4) ? 1 : 5);
            @(negedge clk_d);
            tick_1hz = 1'b0;
        end
        cyc(0, 0, 0, 0, 0);
        check("timer exit elapsed", 32'(elapsed_b), 0);
        check("timer exit status", 32'(status_b), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
